// File: rtl/div_unit.sv
// div_unit: 32-bit restoring divider for DIV/DIVU/REM/REMU with register-file writeback.
// Ports: clk, rst (async, active-high); start, op[1:0] (00 DIV, 01 DIVU, 10 REM, 11 REMU),
//   rs1_data (dividend), rs2_data (divisor), rd_in -> busy, done (1-cycle pulse), result,
//   rd_out, regwrite.
// Option: DIV_EARLY_OUT_EN makes divide-by-zero and signed overflow skip the 32 CALC cycles.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        regwrite
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;
  logic [4:0] cnt, rd_q;
  logic [31:0] q, r, b, diff, q_n, r_n, quot, rem;
  logic [32:0] rs;
  logic is_rem, neg_q, neg_r, dz, ge, s1, s2, early;
  assign s1 = ~op[0] & rs1_data[31];
  assign s2 = ~op[0] & rs2_data[31];
`ifdef DIV_EARLY_OUT_EN
  logic dz_in, ovf_in;
  logic [31:0] early_res;
  assign dz_in = rs2_data == 32'd0;
  assign ovf_in = ~op[0] && rs1_data == 32'h8000_0000 && rs2_data == 32'hFFFF_FFFF;
  assign early = dz_in | ovf_in;
  assign early_res = op[1] ? (dz_in ? rs1_data : 32'd0) : (dz_in ? 32'hFFFF_FFFF : 32'h8000_0000);
`else
  assign early = 1'b0;
`endif
  // q starts as the dividend magnitude and shifts its bits into r while quotient bits shift in.
  // A zero divisor naturally gives q=all ones and r=|dividend|; only signed DIV needs overriding.
  always_comb begin
    rs = {r, q[31]};
    ge = rs >= {1'b0, b};
    diff = rs[31:0] - b;
    r_n = ge ? diff : rs[31:0];
    q_n = {q[30:0], ge};
    quot = dz ? 32'hFFFF_FFFF : (neg_q ? -q_n : q_n);
    rem = neg_r ? -r_n : r_n;
  end
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? (start ? (early ? DONE : CALC) : IDLE)
               : state == CALC ? (cnt == 5'd31 ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      q <= '0;
      r <= '0;
      b <= '0;
      is_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      rd_q <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      q <= s1 ? -rs1_data : rs1_data;
      r <= '0;
      b <= s2 ? -rs2_data : rs2_data;
      is_rem <= op[1];
      neg_q <= s1 ^ s2;
      neg_r <= s1;
      dz <= rs2_data == 32'd0;
      rd_q <= rd_in;
`ifdef DIV_EARLY_OUT_EN
      if (early) begin
        result <= early_res;
        rd_out <= rd_in;
      end
`endif
    end else if (state == CALC) begin
      q <= q_n;
      r <= r_n;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        result <= is_rem ? rem : quot;
        rd_out <= rd_q;
      end
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign regwrite = done && rd_out != 5'd0;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed table-driven bench for div_unit plus reset and start-flood sequences.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0] rd_in;
  logic busy, done, regwrite;
  logic [31:0] result;
  logic [4:0] rd_out;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a, b;
    logic [4:0] rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];
  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out), .regwrite(regwrite)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input string name, input vec_t v);
    int k, lat;
    logic early;
    early = v.b == 32'd0 || (!v.op[0] && v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    lat = early ? 0 : 32;
`else
    lat = 32;
`endif
    @(negedge clk);
    start = 1'b1; op = v.op; rs1_data = v.a; rs2_data = v.b; rd_in = v.rd;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    @(negedge clk);
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, k, lat);
    check({name, " result"}, result, v.exp);
    check({name, " regwrite"}, {31'd0, regwrite}, {31'd0, v.rd != 5'd0});
    check({name, " rd_out"}, {27'd0, rd_out}, {27'd0, v.rd});
    @(negedge clk);
    check({name, " done_pulse"}, {31'd0, done}, 32'd0);
    check({name, " result_hold"}, result, v.exp);
  endtask
  initial begin
    int n;
    vecs[0]  = '{2'b01, 32'd100, 32'd7, 5'd5, 32'd14};
    vecs[1]  = '{2'b11, 32'd100, 32'd7, 5'd5, 32'd2};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1};
    vecs[5]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0};
    vecs[7]  = '{2'b01, 32'd55, 32'd0, 5'd8, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b11, 32'd55, 32'd0, 5'd0, 32'd55};
    vecs[9]  = '{2'b00, 32'd0, 32'd5, 5'd9, 32'd0};
    vecs[10] = '{2'b11, 32'd0, 32'd5, 5'd10, 32'd0};
    vecs[11] = '{2'b00, 32'd100, 32'hFFFF_FFF9, 5'd11, 32'hFFFF_FFF2};
    vecs[12] = '{2'b00, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFFF};
    vecs[13] = '{2'b10, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFF9};
    vecs[14] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF};
    rst = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst regwrite", {31'd0, regwrite}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;
    foreach (vecs[i]) run($sformatf("v%0d", i), vecs[i]);
    // reset in the middle of a DIVU 100/7
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n++;
    end
    check("midrst no_done", n, 0);
    check("midrst result_after", result, 32'd0);
    // start held high through CALC and through the DONE->IDLE edge
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd5;
    @(posedge clk);
    #1 rs1_data = 32'd1000; rs2_data = 32'd3; op = 2'b11; rd_in = 5'd9;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) begin
        n++;
        check("flood result", result, 32'd14);
        check("flood rd_out", {27'd0, rd_out}, 32'd5);
        break;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) n++;
    end
    check("flood done_count", n, 1);
    check("flood busy", {31'd0, busy}, 32'd0);
    check("flood result_hold", result, 32'd14);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and the register index width at 5 bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only while busy=0.
REQ-005 op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 rs1_data  input  32  dividend, from register file read port 1.
REQ-007 rs2_data  input  32  divisor, from register file read port 2.
REQ-008 rd_in  input  5  destination register index for the result.
REQ-009 busy  output  1  high while an operation is in flight (states CALC and DONE).
REQ-010 done  output  1  one-cycle pulse; result is valid while high.
REQ-011 result  output  32  quotient or remainder; drives register file write data.
REQ-012 rd_out  output  5  latched rd_in; drives the register file write index.
REQ-013 regwrite  output  1  equals done and rd_out!=0; drives the register file write enable.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL latch op, rd_in, the dividend and divisor magnitudes (signed ops) or raw values (unsigned ops), and both sign bits, then go to CALC with the iteration counter at 0.
REQ-016 In CALC, the block SHALL perform one restoring shift-subtract step per cycle, for exactly 32 cycles, then go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle and the state SHALL return to IDLE on the next edge.
REQ-018 Normal latency SHALL be fixed: with start sampled at edge N, done is high between edges N+32 and N+33.
REQ-019 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-020 start at the edge on which DONE returns to IDLE SHALL be ignored; a new operation is accepted only while busy=0.
REQ-021 For a signed quotient, the result SHALL be negated when the operand signs differ; a signed remainder SHALL take the sign of the dividend.
REQ-022 Division by zero SHALL yield 0xFFFFFFFF for DIV/DIVU and the unmodified dividend for REM/REMU.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield 0x80000000 for DIV and 0 for REM.
REQ-024 result and rd_out SHALL hold their last value after done falls, until the next DONE.
REQ-025 A dividend of 0 with a nonzero divisor SHALL yield 0 for all ops.

Reset
REQ-026 rst=1 SHALL force IDLE immediately, regardless of the clock, and abort any operation in flight.
REQ-027 During reset, busy, done, regwrite SHALL be 0, result SHALL be 0x00000000, and rd_out SHALL be 0.
REQ-028 After rst falls, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-029 With DIV_EARLY_OUT_EN defined, division by zero and signed overflow SHALL skip CALC: IDLE goes to DONE at edge N, and done is high between N and N+1.
REQ-030 Without DIV_EARLY_OUT_EN, all operations SHALL take the REQ-018 latency, and the REQ-022/023 results SHALL be unchanged.

Verification
REQ-031 Reset mid-operation: start DIVU 100/7, assert rst at cycle 10 -> busy=0, done never pulses, and result=0.
REQ-032 DIVU 100/7 rd=5, then REMU with the same operands -> results 14, then 2; done pulses at N+32; regwrite=1; rd_out=5.
REQ-033 DIV -7/2 (0xFFFFFFF9/2) -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; the latency is 1 cycle with DIV_EARLY_OUT_EN and 33 cycles without.
REQ-035 DIVU 55/0 -> 0xFFFFFFFF; REMU 55/0 -> 55; rd=0 -> done=1 and regwrite=0.
REQ-036 start pulsed every cycle during CALC -> exactly one done pulse, with the first operation's result.
